// File: rtl/mips_pkg.sv
// Shared MIPS control encodings: ALU control, R-type funct codes for the
// multiply/divide unit, and the multiply/divide FSM state type.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide datapath: operand magnitudes, one radix-2
// shift-add or restoring-divide step per cycle, and final sign fix-up.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             div_op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  // acc_r: product high half / partial remainder; sh_r: multiplier / quotient
  logic [WIDTH-1:0]   acc_r, sh_r, opd_r;
  logic               div_r, neg_q_r, neg_r_r, zero_r;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, acc_nx_s, sh_nx_s, diff_s;
  logic [WIDTH:0]     sum_s, shift_s;
  logic [2*WIDTH-1:0] prod_s;

  // Operand magnitudes (the most-negative value maps onto itself as unsigned)
  always_comb begin
    a_mag_s = (signed_op && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    b_mag_s = (signed_op && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
  end

  // One iteration: conditional add-and-shift, or trial subtract-and-shift
  always_comb begin
    sum_s    = {1'b0, acc_r} + {1'b0, opd_r};
    shift_s  = {acc_r, sh_r[WIDTH-1]};
    diff_s   = shift_s[WIDTH-1:0] - opd_r;
    acc_nx_s = acc_r;
    sh_nx_s  = sh_r;
    if (div_r) begin
      if (shift_s >= {1'b0, opd_r}) begin
        acc_nx_s = diff_s;
        sh_nx_s  = {sh_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx_s = shift_s[WIDTH-1:0];
        sh_nx_s  = {sh_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (sh_r[0]) begin
        {acc_nx_s, sh_nx_s} = {sum_s, sh_r[WIDTH-1:1]};
      end else begin
        {acc_nx_s, sh_nx_s} = {1'b0, acc_r, sh_r[WIDTH-1:1]};
      end
    end
  end

  // Operand latch on acceptance, iteration while stepping
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r   <= {WIDTH{1'b0}};
      sh_r    <= {WIDTH{1'b0}};
      opd_r   <= {WIDTH{1'b0}};
      div_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      zero_r  <= 1'b0;
    end else if (load) begin
      acc_r   <= {WIDTH{1'b0}};
      sh_r    <= a_mag_s;
      opd_r   <= b_mag_s;
      div_r   <= div_op;
      neg_q_r <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r_r <= signed_op & a[WIDTH-1];
      zero_r  <= div_op & (b == {WIDTH{1'b0}});
    end else if (step) begin
      acc_r <= acc_nx_s;
      sh_r  <= sh_nx_s;
    end else begin
      acc_r <= acc_r;
      sh_r  <= sh_r;
    end
  end

  // Sign fix-up; a zero divisor leaves the remainder equal to a
  always_comb begin
    prod_s = {acc_r, sh_r};
    prod_s = neg_q_r ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
    if (div_r) begin
      res_lo = zero_r ? {WIDTH{1'b1}} : (neg_q_r ? ({WIDTH{1'b0}} - sh_r) : sh_r);
      res_hi = neg_r_r ? ({WIDTH{1'b0}} - acc_r) : acc_r;
    end else begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end
    div_zero = zero_r;
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: decode, control FSM, iteration counter
// and the architectural HI/LO registers around muldiv_datapath.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_e        state_r, state_s;
  logic [CW-1:0]    cnt_r;
  logic             is_op_s, div_op_s, signed_op_s, accept_s;
  logic             load_s, step_s, wr_res_s, wr_hi_s, wr_lo_s;
  logic             busy_s, done_s, dbz_s, busy_r, done_r, dbz_r;
  logic [WIDTH-1:0] hi_r, lo_r, res_hi_s, res_lo_s;
  logic             div_zero_s;

  // Funct decode for the iterative operations
  always_comb begin
    case (funct)
      FUNCT_MULT:  begin is_op_s = 1'b1; div_op_s = 1'b0; signed_op_s = 1'b1; end
      FUNCT_MULTU: begin is_op_s = 1'b1; div_op_s = 1'b0; signed_op_s = 1'b0; end
      FUNCT_DIV:   begin is_op_s = 1'b1; div_op_s = 1'b1; signed_op_s = 1'b1; end
      FUNCT_DIVU:  begin is_op_s = 1'b1; div_op_s = 1'b1; signed_op_s = 1'b0; end
      default:     begin is_op_s = 1'b0; div_op_s = 1'b0; signed_op_s = 1'b0; end
    endcase
    accept_s = start && ((state_r == IDLE) || (state_r == DONE));
  end

  // State register and iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= (state_r == CALC && !load_s) ? cnt_r + CNT_ONE : {CW{1'b0}};
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: state_s = (accept_s && is_op_s) ? CALC : IDLE;
      CALC:       state_s = (cnt_r == CNT_LAST) ? SIGN : CALC;
      SIGN:       state_s = DONE;
      default:    state_s = IDLE;
    endcase
  end

  // Control and status decode from the current state
  always_comb begin
    load_s   = accept_s && is_op_s;
    step_s   = (state_r == CALC);
    wr_res_s = (state_r == SIGN);
    wr_hi_s  = accept_s && (funct == FUNCT_MTHI);
    wr_lo_s  = accept_s && (funct == FUNCT_MTLO);
    busy_s   = (state_r == CALC) || (state_r == SIGN);
    done_s   = (state_r == DONE);
    dbz_s    = (state_r == DONE) && div_zero_s;
  end

  // Registered status outputs and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      dbz_r  <= dbz_s;
      if (wr_res_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else begin
        hi_r <= wr_hi_s ? a : hi_r;
        lo_r <= wr_lo_s ? a : lo_r;
      end
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .step      (step_s),
    .div_op    (div_op_s),
    .signed_op (signed_op_s),
    .a         (a),
    .b         (b),
    .res_hi    (res_hi_s),
    .res_lo    (res_lo_s),
    .div_zero  (div_zero_s)
  );

  assign busy = busy_r;
  assign done = done_r;
  assign dbz  = dbz_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are even and at least 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: requests the operation selected by funct.
REQ-005 SHALL have port funct, input, 6 bits: R-type function field (MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011).
REQ-006 SHALL have ports a and b, inputs, WIDTH bits each: rs and rt operands.
REQ-007 SHALL have port busy, output, 1 bit: high while a multiply or divide is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the result is written.
REQ-009 SHALL have port dbz, output, 1 bit: divide-by-zero flag, valid while done is high.
REQ-010 SHALL have ports hi and lo, outputs, WIDTH bits each: the architectural HI/LO registers, always readable.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, SIGN and DONE.
REQ-012 SHALL accept start only in IDLE or DONE; start in CALC or SIGN SHALL be ignored with no side effects.
REQ-013 SHALL write a to hi (MTHI) or a to lo (MTLO) at the accepting edge, in one cycle, leaving the FSM in IDLE with done low.
REQ-014 SHALL, on an accepted MULT/MULTU/DIV/DIVU, latch operand magnitudes (absolute values for signed ops) and result signs, then enter CALC with the iteration counter at 0.
REQ-015 SHALL ignore start when funct is unrecognised; the state stays IDLE.
REQ-016 SHALL, in CALC, run one radix-2 iteration per cycle (shift-add multiply or restoring divide) for exactly WIDTH cycles, then go to SIGN.
REQ-017 SHALL, in SIGN, apply signs and write hi/lo in one cycle, then go to DONE; DONE SHALL last one cycle and then return to IDLE unless a new start is accepted.
REQ-018 SHALL give this latency: with start accepted at edge k, busy is high from edge k+1 to edge k+WIDTH+1, and done is high with hi/lo valid from edge k+WIDTH+2 for one cycle.
REQ-019 SHALL produce these multiply results: {hi,lo} = the 2*WIDTH-bit product; MULT is two's-complement signed, MULTU is unsigned.
REQ-020 SHALL produce these divide results: lo = quotient truncated toward zero, hi = remainder with the sign of a; DIVU is unsigned.
REQ-021 SHALL, for signed DIV of the most-negative value by -1, give lo = the most-negative value and hi = 0, with no flag.
REQ-022 SHALL, for b = 0 on DIV/DIVU, give lo = all ones, hi = a unchanged, and dbz = 1 with done; the full latency still applies.
REQ-023 SHALL leave hi/lo unchanged from acceptance until the SIGN write.
REQ-024 SHALL hold dbz low except in DONE.

Reset
REQ-025 SHALL, when reset is high at an edge, force state IDLE, counter 0, hi = 0, lo = 0, busy = 0, done = 0 and dbz = 0, overriding any start.
REQ-026 SHALL, when reset occurs mid-CALC, abandon the operation, discard partial results and produce no done pulse.

Structure
REQ-027 SHALL take the funct codes and the FSM state enum from a shared package, mips_pkg, alongside the existing ALU-control encodings.
REQ-028 SHALL contain one sub-module, muldiv_datapath, holding the shift registers, adder/subtractor and sign fix-up; the FSM and counter stay in muldiv_unit.

Verification
REQ-029 SHALL cover, at WIDTH=32: MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 edges after acceptance.
REQ-030 SHALL cover: MULT with a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV with a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 SHALL cover: DIVU with a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007, dbz=1 during the done cycle only.
REQ-032 SHALL cover: DIV with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, dbz=0.
REQ-033 SHALL cover: start with MTHI a=0x1234 pulsed at cycle 10 of a CALC -> ignored; after done, MTHI a=0x1234 -> hi=0x1234 next edge with lo unchanged.
REQ-034 SHALL cover: reset asserted at CALC cycle 5 -> busy=0 and hi=lo=0 next edge, and no done pulse within the following 40 cycles.
